// File: rtl/snake_uart_reporter_if.sv
// +----------------------------------------------------------------------------+
// | snake_uart_reporter_if: game-event request side and UART TX FIFO side.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface snake_uart_reporter_if;
  logic       send_req;
  logic [1:0] event_code;
  logic [9:0] score;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic       done;

  modport master (
    output send_req, event_code, score, tx_full,
    input  wr_uart, w_data, busy, done
  );

  modport slave (
    input  send_req, event_code, score, tx_full,
    output wr_uart, w_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/snake_uart_reporter.sv
// +----------------------------------------------------------------------------+
// | snake_uart_reporter: formats a game event + score as ASCII into UART TX.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module snake_uart_reporter #(
  parameter int CRLF_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  snake_uart_reporter_if.slave        bus
);

  localparam logic [2:0] LAST_IDX = (CRLF_EN != 0) ? 3'd5 : 3'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_H = 3'd1,
    CONV_T = 3'd2,
    SEND   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_prefix, w_prefix;
  logic [9:0] r_rem, w_rem;
  logic [3:0] r_hund, w_hund;
  logic [3:0] r_tens, w_tens;
  logic [3:0] r_ones, w_ones;
  logic [2:0] r_idx, w_idx;
  logic       r_wr, w_wr;
  logic [7:0] r_data, w_data_nxt;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic [7:0] w_byte;

  always_comb begin
    case (r_idx)
      3'd0:    w_byte = r_prefix;
      3'd1:    w_byte = 8'h30 + {4'h0, r_hund};
      3'd2:    w_byte = 8'h30 + {4'h0, r_tens};
      3'd3:    w_byte = 8'h30 + {4'h0, r_ones};
      3'd4:    w_byte = 8'h0D;
      3'd5:    w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_prefix   = r_prefix;
    w_rem      = r_rem;
    w_hund     = r_hund;
    w_tens     = r_tens;
    w_ones     = r_ones;
    w_idx      = r_idx;
    w_wr       = 1'b0;
    w_data_nxt = r_data;
    w_busy     = r_busy;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.send_req) begin
          case (bus.event_code)
            2'd0:    w_prefix = 8'h53;
            2'd1:    w_prefix = 8'h47;
            2'd2:    w_prefix = 8'h52;
            default: w_prefix = 8'h3F;
          endcase
          w_rem   = (bus.score > 10'd999) ? 10'd999 : bus.score;
          w_hund  = 4'd0;
          w_tens  = 4'd0;
          w_busy  = 1'b1;
          w_state = CONV_H;
        end
      end
      // Repeated subtraction keeps the datapath to one comparator/subtractor per digit.
      CONV_H: begin
        if (r_rem >= 10'd100) begin
          w_rem  = r_rem - 10'd100;
          w_hund = r_hund + 4'd1;
        end else begin
          w_state = CONV_T;
        end
      end
      CONV_T: begin
        if (r_rem >= 10'd10) begin
          w_rem  = r_rem - 10'd10;
          w_tens = r_tens + 4'd1;
        end else begin
          w_ones  = r_rem[3:0];
          w_idx   = 3'd0;
          w_state = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_full) begin
          w_wr       = 1'b1;
          w_data_nxt = w_byte;
          w_state    = GAP;
        end
      end
      // One idle cycle so tx_full can reflect the write just made.
      GAP: begin
        if (r_idx == LAST_IDX) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = FINISH;
        end else begin
          w_idx   = r_idx + 3'd1;
          w_state = SEND;
        end
      end
      FINISH: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_prefix <= 8'h00;
      r_rem    <= 10'd0;
      r_hund   <= 4'd0;
      r_tens   <= 4'd0;
      r_ones   <= 4'd0;
      r_idx    <= 3'd0;
      r_wr     <= 1'b0;
      r_data   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_prefix <= w_prefix;
      r_rem    <= w_rem;
      r_hund   <= w_hund;
      r_tens   <= w_tens;
      r_ones   <= w_ones;
      r_idx    <= w_idx;
      r_wr     <= w_wr;
      r_data   <= w_data_nxt;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign bus.wr_uart = r_wr;
  assign bus.w_data  = r_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

`default_nettype wire
